sum_display_scanner: RTL and testbench



---
 rtl/sum_display_pkg.sv | 26 ++
 rtl/sum_display_scanner_seg7_decode.sv | 12 +
 rtl/sum_display_scanner.sv | 168 ++++++++++++++++
 tb/tb_sum_display_scanner.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_display_pkg.sv
// Shared types and glyph constants for the two-digit sum display scanner.
// Glyph bit0 = segment a ... bit6 = segment g, active low.
package sum_display_pkg;

   typedef enum logic [1:0] {
      BLANK0,
      SHOW0,
      BLANK1,
      SHOW1
   } scanState_e;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Index 0 is the rightmost entry; lowercase b and d glyphs.
   localparam logic [15:0][6:0] GLYPHS = {
      7'h0E, 7'h06, 7'h21, 7'h46,
      7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19,
      7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic logic [6:0] glyph(input logic [3:0] d);
      return GLYPHS[d];
   endfunction

endpackage

// File: rtl/sum_display_scanner_seg7_decode.sv
// Combinational 4-bit digit to active-low 7-segment decoder.
// Shared by both digit slots through a mux in the top level.
module seg7_decode
   import sum_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   assign seg = glyph(digit);

endmodule

// File: rtl/sum_display_scanner.sv
// Two-digit multiplexed 7-segment scanner for the 5-bit adder result.
// Display value is swapped only at frame boundaries so a frame never tears.
module sum_display_scanner
   import sum_display_pkg::*;
#(
   parameter int PRESCALE = 50000,
   parameter int DEAD     = 4
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Enable,
   input  logic [4:0] SumIn,
   input  logic       SumValid,
   input  logic       HexMode,
   output logic [6:0] Seg_n,
   output logic [1:0] An_n,
   output logic       FrameTick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   scanState_e    state;
   scanState_e    stateNext;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cntNext;
   logic          started;
   logic          startedNext;
   logic          load;
   logic          upperSlot;

   logic [4:0]    pending;
   logic [4:0]    display;

   logic [3:0]    unitsDigit;
   logic [3:0]    upperDigit;
   logic [3:0]    digit;
   logic [6:0]    glyphSeg;
   logic [6:0]    segNext;
   logic [1:0]    anNext;

   function automatic scanState_e slotState(
      input logic          upper,
      input logic [CW-1:0] c
   );
      logic blank;
      blank = (int'(c) < DEAD);
      unique case ({upper, blank})
         2'b01:   return BLANK0;
         2'b00:   return SHOW0;
         2'b11:   return BLANK1;
         default: return SHOW1;
      endcase
   endfunction

   assign upperSlot = (state == BLANK1) || (state == SHOW1);

   // started=0 marks the single load cycle that opens the first frame
   // after reset or re-enable.
   always_comb begin
      stateNext   = state;
      cntNext     = cnt;
      startedNext = started;
      load        = 1'b0;
      unique case (1'b1)
         !Enable: begin
            stateNext   = BLANK0;
            cntNext     = '0;
            startedNext = 1'b0;
         end
         Enable && !started: begin
            stateNext   = slotState(1'b0, '0);
            cntNext     = '0;
            startedNext = 1'b1;
            load        = 1'b1;
         end
         default: begin
            if (cnt == LAST) begin
               cntNext   = '0;
               stateNext = slotState(!upperSlot, '0);
               load      = upperSlot;
            end else begin
               cntNext   = cnt + 1'b1;
               stateNext = slotState(upperSlot, cnt + 1'b1);
            end
         end
      endcase
   end

   always_comb begin
      unitsDigit = display[3:0];
      upperDigit = {3'b000, display[4]};
      if (!HexMode) begin
         unique case (1'b1)
            display >= 5'd30: begin
               upperDigit = 4'd3;
               unitsDigit = 4'(display - 5'd30);
            end
            display >= 5'd20 && display < 5'd30: begin
               upperDigit = 4'd2;
               unitsDigit = 4'(display - 5'd20);
            end
            display >= 5'd10 && display < 5'd20: begin
               upperDigit = 4'd1;
               unitsDigit = 4'(display - 5'd10);
            end
            default: begin
               upperDigit = 4'd0;
               unitsDigit = display[3:0];
            end
         endcase
      end
   end

   assign digit = upperSlot ? upperDigit : unitsDigit;

   seg7_decode u_decode (
      .digit (digit),
      .seg   (glyphSeg)
   );

   always_comb begin
      segNext = SEG_OFF;
      anNext  = 2'b11;
      if (Enable && started) begin
         unique case (state)
            SHOW0: begin
               segNext = glyphSeg;
               anNext  = 2'b10;
            end
            SHOW1: begin
               if (upperDigit != 4'd0) begin
                  segNext = glyphSeg;
                  anNext  = 2'b01;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state     <= BLANK0;
         cnt       <= '0;
         started   <= 1'b0;
         pending   <= '0;
         display   <= '0;
         Seg_n     <= SEG_OFF;
         An_n      <= 2'b11;
         FrameTick <= 1'b0;
      end else begin
         state     <= stateNext;
         cnt       <= cntNext;
         started   <= startedNext;
         Seg_n     <= segNext;
         An_n      <= anNext;
         FrameTick <= load;
         if (load) begin
            display <= pending;
         end
         if (SumValid) begin
            pending <= SumIn;
         end
      end
   end

endmodule

// File: tb/tb_sum_display_scanner.sv
// Randomized and directed bench for sum_display_scanner against a
// frame-position reference model.
module tb_sum_display_scanner;

   localparam int P = 8;
   localparam int D = 2;
   localparam int F = 2 * P;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic       Enable = 1'b0;
   logic [4:0] SumIn = '0;
   logic       SumValid = 1'b0;
   logic       HexMode = 1'b0;
   logic [6:0] Seg_n;
   logic [1:0] An_n;
   logic       FrameTick;

   int checks = 0;
   int failures = 0;

   logic [6:0] glyphs [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   bit         mStarted = 0;
   int         mK = 0;
   int         mPend = 0;
   int         mDisp = 0;
   logic [6:0] eSeg;
   logic [1:0] eAn;
   logic       eFt;

   logic [6:0] lastU = '0;
   logic [6:0] lastH = '0;
   bit         seenUpper = 0;
   bit         saw12 = 0;

   always #5 Clk = ~Clk;

   sum_display_scanner #(
      .PRESCALE (P),
      .DEAD     (D)
   ) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .Enable    (Enable),
      .SumIn     (SumIn),
      .SumValid  (SumValid),
      .HexMode   (HexMode),
      .Seg_n     (Seg_n),
      .An_n      (An_n),
      .FrameTick (FrameTick)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected outputs after this edge, from the frame position mK.
   task automatic modelStep();
      int pos;
      int up;
      int un;
      eSeg = 7'h7F;
      eAn  = 2'b11;
      eFt  = 1'b0;
      if (!Rst_n) begin
         mStarted = 0;
         mK = 0;
         mPend = 0;
         mDisp = 0;
         return;
      end
      if (!Enable) begin
         mStarted = 0;
      end else if (!mStarted) begin
         eFt = 1'b1;
         mDisp = mPend;
         mStarted = 1;
         mK = 0;
      end else begin
         pos = mK % F;
         if (HexMode) begin
            up = mDisp / 16;
            un = mDisp % 16;
         end else begin
            up = mDisp / 10;
            un = mDisp % 10;
         end
         if ((pos % P) >= D) begin
            if (pos < P) begin
               eAn = 2'b10;
               eSeg = glyphs[un];
            end else if (up != 0) begin
               eAn = 2'b01;
               eSeg = glyphs[up];
            end
         end
         if (pos == F - 1) begin
            eFt = 1'b1;
            mDisp = mPend;
         end
         mK++;
      end
      if (SumValid) mPend = SumIn;
   endtask

   task automatic cyc();
      @(posedge Clk);
      modelStep();
      #1;
      check("seg", Seg_n, eSeg);
      check("an", An_n, eAn);
      check("ft", FrameTick, eFt);
      if (An_n == 2'b10) lastU = Seg_n;
      if (An_n == 2'b01) begin
         lastH = Seg_n;
         seenUpper = 1;
         if (Seg_n == 7'h79) saw12 = 1;
      end
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic pulse(input logic [4:0] v);
      SumIn = v;
      SumValid = 1'b1;
      cyc();
      SumValid = 1'b0;
   endtask

   task automatic waitPos(input int p);
      int n = 0;
      while (!(mStarted && (mK % F) == p) && n < 64) begin
         cyc();
         n++;
      end
      check("wait_bound", n < 64, 1'b1);
   endtask

   // Start-of-frame sequence: load cycle, DEAD blank cycles, then units.
   task automatic startCheck(input string tag);
      cyc();
      check({tag, "_ft"}, FrameTick, 1'b1);
      check({tag, "_an0"}, An_n, 2'b11);
      cyc();
      check({tag, "_an1"}, An_n, 2'b11);
      cyc();
      check({tag, "_an2"}, An_n, 2'b11);
      cyc();
      check({tag, "_an3"}, An_n, 2'b10);
   endtask

   initial begin
      Enable = 1'b1;
      Rst_n = 1'b0;
      run(3);
      check("rst_seg", Seg_n, 7'h7F);
      check("rst_an", An_n, 2'b11);
      Rst_n = 1'b1;
      startCheck("rel");

      run(9);
      Rst_n = 1'b0;
      cyc();
      check("rstmid_seg", Seg_n, 7'h7F);
      check("rstmid_an", An_n, 2'b11);
      check("rstmid_ft", FrameTick, 1'b0);
      run(2);
      Rst_n = 1'b1;
      startCheck("rel2");

      pulse(5'd23);
      run(2 * F + 4);
      check("d23_u", lastU, 7'h30);
      check("d23_h", lastH, 7'h24);

      Enable = 1'b0;
      cyc();
      HexMode = 1'b1;
      Enable = 1'b1;
      pulse(5'h1A);
      run(2 * F + 4);
      check("h1a_u", lastU, 7'h08);
      check("h1a_h", lastH, 7'h79);
      Enable = 1'b0;
      cyc();
      HexMode = 1'b0;
      Enable = 1'b1;

      pulse(5'd7);
      run(2 * F + 4);
      seenUpper = 0;
      run(F);
      check("lz7_u", lastU, 7'h78);
      check("lz7_h", seenUpper, 1'b0);
      pulse(5'd0);
      run(2 * F + 4);
      check("zero_u", lastU, 7'h40);

      waitPos(F - 1);
      cyc();
      saw12 = 0;
      pulse(5'd12);
      run(3);
      pulse(5'd31);
      run(2 * F);
      check("tear_12", saw12, 1'b0);
      check("tear_u", lastU, 7'h79);
      check("tear_h", lastH, 7'h30);

      waitPos(F - 1);
      SumIn = 5'd5;
      SumValid = 1'b1;
      cyc();
      SumValid = 1'b0;
      run(F);
      check("bnd_old", lastU, 7'h79);
      run(F);
      check("bnd_new", lastU, 7'h12);

      waitPos(F - 4);
      Enable = 1'b0;
      cyc();
      check("en_off_an", An_n, 2'b11);
      run(2);
      Enable = 1'b1;
      startCheck("reen");

      for (int i = 0; i < 1200; i++) begin
         Rst_n = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 59) == 0) Enable = ~Enable;
         if (!Enable && $urandom_range(0, 3) == 0)
            HexMode = 1'($urandom_range(0, 1));
         SumValid = ($urandom_range(0, 7) == 0);
         SumIn = 5'($urandom_range(0, 31));
         cyc();
      end
      Rst_n = 1'b1;
      SumValid = 1'b0;
      Enable = 1'b1;
      run(F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
